mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 28, block (line) address width; LINE_W, default 128, line data width.
REQ-002 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have I-side ports: ic_mem_read in 1 line-fill request (level, held until ready); ic_mem_addr in ADDR_W; ic_mem_rdata out LINE_W; ic_mem_ready out 1.
REQ-005 SHALL have D-side ports: dc_mem_read in 1; dc_mem_write in 1; dc_mem_addr in ADDR_W; dc_mem_wdata in LINE_W; dc_mem_rdata out LINE_W; dc_mem_ready out 1.
REQ-006 SHALL have memory-side ports: mem_read out 1; mem_write out 1; mem_addr out ADDR_W; mem_wdata out LINE_W; mem_rdata in LINE_W; mem_ready in 1 (one-cycle completion pulse).

Function
REQ-007 SHALL implement FSM states IDLE, GRANT_I, GRANT_D, RELEASE.
REQ-008 IDLE: pending I = ic_mem_read; pending D = dc_mem_read | dc_mem_write; no pending request -> stay IDLE.
REQ-009 IDLE, only one side pending -> that side's GRANT state next edge.
REQ-010 IDLE, both pending -> grant the side not granted last (last_grant register); last_grant resets to I, so the first tie goes to D.
REQ-011 At the grant edge SHALL register mem_addr, mem_wdata, mem_read and mem_write from the winner; these outputs remain stable for the whole grant.
REQ-012 D grant with dc_mem_write=1 -> mem_write=1, mem_read=0, regardless of dc_mem_read; otherwise mem_read=1; I grant -> mem_read=1 only.
REQ-013 mem_read and mem_write SHALL never both be 1; both SHALL be 0 outside GRANT_I/GRANT_D.
REQ-014 In GRANT_x, ready_x = mem_ready combinationally (zero added latency); the non-owner ready SHALL be 0.
REQ-015 ic_mem_rdata and dc_mem_rdata SHALL both equal mem_rdata unconditionally; requesters qualify the data with their own ready.
REQ-016 GRANT_x with mem_ready=1 -> RELEASE next edge; mem_read/mem_write cleared at that edge; last_grant updated to x.
REQ-017 GRANT_x with mem_ready=0 -> stay; requester dropping its request mid-grant SHALL be ignored (transaction completes).
REQ-018 RELEASE: one bubble cycle with no grant and requests ignored -> IDLE next edge; this lets a requester drop its request after ready.
REQ-019 Minimum service time per transaction from IDLE: 1 cycle to grant + memory latency + 1 RELEASE cycle.
REQ-020 mem_ready outside GRANT states SHALL be ignored with no ready forwarded.
REQ-021 Fairness: with both sides continuously pending, grants SHALL strictly alternate I/D.

Reset
REQ-022 rst_n=0 SHALL immediately force state=IDLE, last_grant=I, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, ic_mem_ready=0, dc_mem_ready=0, including mid-transaction.
REQ-023 After rst_n deasserts, the first grant SHALL occur no earlier than the first rising edge with rst_n=1.

Structure
REQ-024 A shared package SHALL hold the state enum (IDLE, GRANT_I, GRANT_D, RELEASE), the last_grant encoding, and the ADDR_W/LINE_W defaults.
REQ-025 A single sub-module, mem_arb_rr (combinational 2-way round-robin picker: req_i, req_d, last_grant -> grant_i, grant_d), is natural; everything else stays in mem_arbiter.

Verification
REQ-026 I-only: ic_mem_read=1, addr=0x0000010, memory ready after 4 cycles -> mem_read=1 with mem_addr=0x0000010 from cycle 1; ic_mem_ready pulses 1 cycle with mem_ready; IDLE after 1 RELEASE cycle.
REQ-027 Simultaneous after reset: I addr=0x1, D read addr=0x2 -> D served first (mem_addr=0x2), then I (mem_addr=0x1); dc_mem_ready never asserts during the I grant.
REQ-028 D write-back: dc_mem_write=1 and dc_mem_read=1, wdata=0xDEADBEEF repeated 4x -> mem_write=1, mem_read=0, mem_wdata stable until mem_ready.
REQ-029 Continuous contention, 6 transactions -> grant order D,I,D,I,D,I; mem_read and mem_write never both high.
REQ-030 Reset mid-grant: assert rst_n=0 two cycles into GRANT_I -> mem_read=0 and ready outputs 0 in the same cycle; after release, a tie is granted to D.
REQ-031 Stray mem_ready pulse in IDLE or RELEASE -> no ready output and no state change.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-requester line-fill memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 28;
  localparam int unsigned LINE_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  typedef enum logic {
    LAST_I = 1'b0,
    LAST_D = 1'b1
  } last_grant_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of I-side, D-side and memory-side signals around the arbiter.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LINE_W = LINE_W_DEF
);
  logic              ic_mem_read;
  logic [ADDR_W-1:0] ic_mem_addr;
  logic [LINE_W-1:0] ic_mem_rdata;
  logic              ic_mem_ready;

  logic              dc_mem_read;
  logic              dc_mem_write;
  logic [ADDR_W-1:0] dc_mem_addr;
  logic [LINE_W-1:0] dc_mem_wdata;
  logic [LINE_W-1:0] dc_mem_rdata;
  logic              dc_mem_ready;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;

  // Arbiter side
  modport master (
    input  ic_mem_read, ic_mem_addr,
    output ic_mem_rdata, ic_mem_ready,
    input  dc_mem_read, dc_mem_write, dc_mem_addr, dc_mem_wdata,
    output dc_mem_rdata, dc_mem_ready,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  // Requesters and memory as seen from outside the arbiter
  modport slave (
    output ic_mem_read, ic_mem_addr,
    input  ic_mem_rdata, ic_mem_ready,
    output dc_mem_read, dc_mem_write, dc_mem_addr, dc_mem_wdata,
    input  dc_mem_rdata, dc_mem_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_arb_rr.sv
// Combinational 2-way round-robin picker: a tie goes to the side not granted last.
module mem_arb_rr
  import mem_arbiter_pkg::*;
(
  input  logic        req_i,
  input  logic        req_d,
  input  last_grant_e last_grant,
  output logic        grant_i,
  output logic        grant_d
);

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (req_i && req_d) begin
      grant_d = (last_grant == LAST_I);
      grant_i = !grant_d;
    end else begin
      grant_i = req_i;
      grant_d = req_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/write-backs onto a single memory port,
// with registered memory-side request and a one-cycle bubble after each transaction.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LINE_W = LINE_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.master bus
);

  arb_state_e        state_q, state_d;
  last_grant_e       last_q, last_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;

  logic pend_i, pend_d, gnt_i, gnt_d;

  assign pend_i = bus.ic_mem_read;
  assign pend_d = bus.dc_mem_read | bus.dc_mem_write;

  mem_arb_rr u_rr (
    .req_i      (pend_i),
    .req_d      (pend_d),
    .last_grant (last_q),
    .grant_i    (gnt_i),
    .grant_d    (gnt_d)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    read_d  = read_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_d) begin
          state_d = GRANT_D;
          addr_d  = bus.dc_mem_addr;
          wdata_d = bus.dc_mem_wdata;
          write_d = bus.dc_mem_write;
          read_d  = !bus.dc_mem_write;
        end else if (gnt_i) begin
          state_d = GRANT_I;
          addr_d  = bus.ic_mem_addr;
          wdata_d = '0;
          write_d = 1'b0;
          read_d  = 1'b1;
        end
      end
      GRANT_I: begin
        if (bus.mem_ready) begin
          state_d = RELEASE;
          last_d  = LAST_I;
          read_d  = 1'b0;
          write_d = 1'b0;
        end
      end
      GRANT_D: begin
        if (bus.mem_ready) begin
          state_d = RELEASE;
          last_d  = LAST_D;
          read_d  = 1'b0;
          write_d = 1'b0;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= LAST_I;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      read_q  <= read_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.mem_read  = read_q;
  assign bus.mem_write = write_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  // Ready is forwarded combinationally to the owner only; data is shared.
  assign bus.ic_mem_ready = (state_q == GRANT_I) && bus.mem_ready;
  assign bus.dc_mem_ready = (state_q == GRANT_D) && bus.mem_ready;
  assign bus.ic_mem_rdata = bus.mem_rdata;
  assign bus.dc_mem_rdata = bus.mem_rdata;

endmodule
